buzzer_arbiter: RTL and testbench

- Owns the single piezo buzzer output of the keypad lock and arbitrates between its sound sources: keypress click, unlock success, wrong-code fail and lockout alarm.
- Each source has a fixed tone (square-wave half-period) and envelope (duration, gap).
- Sits between the keypad/lock controller, which issues one-cycle request pulses plus a lockout level, and the buzzer pin.
- Replaces the per-sound counters inside the lock controller.

---
 rtl/buzzer_pkg.sv | 26 ++
 rtl/tone_gen.sv | 34 +++
 rtl/buzzer_arbiter.sv | 102 ++++++++++
 tb/tb_buzzer_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// buzzer_pkg: shared state, source-id and priority definitions for the buzzer arbiter
package buzzer_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_CLICK, ST_OK, ST_FAIL_ON1, ST_FAIL_GAP, ST_FAIL_ON2, ST_ALARM
    } state_t;
    localparam logic [1:0] ID_NONE  = 2'd0;
    localparam logic [1:0] ID_CLICK = 2'd1;
    localparam logic [1:0] ID_OK    = 2'd2;
    localparam logic [1:0] ID_FAIL  = 2'd3;
    localparam logic [2:0] RANK_NONE  = 3'd0;
    localparam logic [2:0] RANK_CLICK = 3'd1;
    localparam logic [2:0] RANK_OK    = 3'd2;
    localparam logic [2:0] RANK_FAIL  = 3'd3;
    localparam logic [2:0] RANK_ALARM = 3'd4;
    function automatic logic [2:0] rank_of(input state_t s);
        return (s == ST_IDLE)  ? RANK_NONE :
               (s == ST_CLICK) ? RANK_CLICK :
               (s == ST_OK)    ? RANK_OK :
               (s == ST_ALARM) ? RANK_ALARM : RANK_FAIL;
    endfunction
    function automatic logic [1:0] id_of(input state_t s);
        return (s == ST_IDLE)  ? ID_NONE :
               (s == ST_CLICK) ? ID_CLICK :
               (s == ST_OK)    ? ID_OK : ID_FAIL;
    endfunction
endpackage

// File: rtl/tone_gen.sv
// tone_gen: registered square-wave generator with restart and enable
// Ports: clk, rst (async, active-high), en (tone allowed, else wave=0 and count held at 0),
//        restart (wave=1, count=0), half (cycles per level), wave (registered output)
module tone_gen #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          restart,
    input  logic [CW-1:0] half,
    output logic          wave
);
    logic [CW-1:0] r_cnt;
    logic          r_wave;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (restart) begin
            r_cnt  <= '0;
            r_wave <= 1'b1;
        end else if (!en) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (r_cnt == half - 1'b1) begin
            r_cnt  <= '0;
            r_wave <= ~r_wave;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end
    assign wave = r_wave;
endmodule

// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: priority arbiter driving the single piezo buzzer of the keypad lock
// Ports: clk, rst (async, active-high); req_click/req_ok/req_fail one-cycle request pulses;
//        lockout level (alarm while high); buzzer registered square wave; busy while sounding;
//        active_id (0 none, 1 click, 2 ok, 3 fail/alarm); done pulse when a timed sound ends
module buzzer_arbiter
    import buzzer_pkg::*;
#(
    parameter int          CW         = 32,
    parameter logic [CW-1:0] CLICK_HALF = 50000,
    parameter logic [CW-1:0] CLICK_DUR  = 10000000,
    parameter logic [CW-1:0] OK_HALF    = 25000,
    parameter logic [CW-1:0] OK_DUR     = 30000000,
    parameter logic [CW-1:0] FAIL_HALF  = 100000,
    parameter logic [CW-1:0] FAIL_SEG   = 5000000,
    parameter logic [CW-1:0] ALM_HALF_A = 40000,
    parameter logic [CW-1:0] ALM_HALF_B = 60000,
    parameter logic [CW-1:0] ALM_SWAP   = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_click,
    input  logic       req_ok,
    input  logic       req_fail,
    input  logic       lockout,
    output logic       buzzer,
    output logic       busy,
    output logic [1:0] active_id,
    output logic       done
);
    state_t        r_state, w_next;
    logic [CW-1:0] r_dur, r_swap, w_half, w_dur_lim;
    logic [1:0]    r_id;
    logic          r_done, r_alm_b, w_alm_b, w_restart, w_done, w_en;
    // Half-period and segment length follow the current state; a new sound restarts the tone anyway.
    assign w_half    = (r_state == ST_CLICK) ? CLICK_HALF :
                       (r_state == ST_OK)    ? OK_HALF :
                       (r_state == ST_ALARM) ? (r_alm_b ? ALM_HALF_B : ALM_HALF_A) : FAIL_HALF;
    assign w_dur_lim = (r_state == ST_CLICK) ? CLICK_DUR :
                       (r_state == ST_OK)    ? OK_DUR : FAIL_SEG;
    assign w_en      = !(w_next inside {ST_IDLE, ST_FAIL_GAP});
    always_comb begin
        w_next    = r_state;
        w_restart = 1'b0;
        w_done    = 1'b0;
        w_alm_b   = r_alm_b;
        if (r_state == ST_ALARM) begin
            if (!lockout) begin
                w_next = ST_IDLE;
            end else if (r_swap == ALM_SWAP - 1'b1) begin
                w_alm_b   = ~r_alm_b;
                w_restart = 1'b1;
            end
        end else if (lockout) begin
            w_next    = ST_ALARM;
            w_alm_b   = 1'b0;
            w_restart = 1'b1;
        end else if (req_fail) begin
            w_next    = ST_FAIL_ON1;
            w_restart = 1'b1;
        end else if (req_ok && rank_of(r_state) <= RANK_OK) begin
            w_next    = ST_OK;
            w_restart = 1'b1;
        end else if (req_click && rank_of(r_state) <= RANK_CLICK) begin
            w_next    = ST_CLICK;
            w_restart = 1'b1;
        end else if (r_state != ST_IDLE && r_dur == w_dur_lim - 1'b1) begin
            w_next    = (r_state == ST_FAIL_ON1) ? ST_FAIL_GAP :
                        (r_state == ST_FAIL_GAP) ? ST_FAIL_ON2 : ST_IDLE;
            w_restart = (r_state == ST_FAIL_GAP);
            w_done    = (w_next == ST_IDLE);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_id    <= ID_NONE;
            r_done  <= 1'b0;
            r_alm_b <= 1'b0;
            r_dur   <= '0;
            r_swap  <= '0;
        end else begin
            r_state <= w_next;
            r_id    <= id_of(w_next);
            r_done  <= w_done;
            r_alm_b <= w_alm_b;
            // Duration counts only while staying in the same timed state without a restart.
            r_dur   <= (w_next == r_state && !w_restart && !(w_next inside {ST_IDLE, ST_ALARM})) ? r_dur + 1'b1 : '0;
            r_swap  <= (w_next == ST_ALARM && !w_restart) ? r_swap + 1'b1 : '0;
        end
    end
    tone_gen #(.CW(CW)) u_tone (
        .clk    (clk),
        .rst    (rst),
        .en     (w_en),
        .restart(w_restart),
        .half   (w_half),
        .wave   (buzzer)
    );
    assign busy      = (r_state != ST_IDLE);
    assign active_id = r_id;
    assign done      = r_done;
endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb_buzzer_arbiter: directed self-checking bench for buzzer_arbiter with small timing parameters
module tb_buzzer_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_click = 1'b0, req_ok = 1'b0, req_fail = 1'b0, lockout = 1'b0;
    logic       buzzer, busy, done;
    logic [1:0] active_id;
    int         checks = 0;
    int         failures = 0;
    logic [0:23] click_pat = {10'b1100110011, 14'b0};
    logic [0:23] ok_pat    = {18'b111000111000111000, 6'b0};
    logic [0:23] fail_pat  = 24'b11001100_00000000_11001100;
    logic [0:23] alarm_pat = 24'b110011001100_111000111000;

    buzzer_arbiter #(
        .CW(32), .CLICK_HALF(2), .CLICK_DUR(10), .OK_HALF(3), .OK_DUR(18),
        .FAIL_HALF(2), .FAIL_SEG(8), .ALM_HALF_A(2), .ALM_HALF_B(3), .ALM_SWAP(12)
    ) dut (
        .clk(clk), .rst(rst), .req_click(req_click), .req_ok(req_ok), .req_fail(req_fail),
        .lockout(lockout), .buzzer(buzzer), .busy(busy), .active_id(active_id), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {buzzer, busy, active_id, done};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed {buzzer,busy,id,done}=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        req_click = 1'b0;
        req_ok    = 1'b0;
        req_fail  = 1'b0;
    endtask

    task automatic go(input logic c, input logic o, input logic f);
        req_click = c;
        req_ok    = o;
        req_fail  = f;
        step();
    endtask

    // Check sound indices [from,to) against a pattern; optionally check the natural end.
    task automatic play(input string tag, input logic [0:23] pat, input int from, input int to,
                        input logic [1:0] id, input bit fin);
        for (int i = from; i < to; i++) begin
            chk($sformatf("%s[%0d]", tag, i), {pat[i], 1'b1, id, 1'b0});
            step();
        end
        if (fin) begin
            chk({tag, "_end"}, 5'b0_0_00_1);
            step();
            chk({tag, "_after"}, 5'b0_0_00_0);
        end
    endtask

    initial begin
        step();
        step();
        chk("reset", 5'b0_0_00_0);
        rst = 1'b0;
        step();
        chk("idle", 5'b0_0_00_0);
        go(1, 0, 0);
        play("click", click_pat, 0, 10, 2'd1, 1);
        go(0, 1, 0);
        play("ok_a", ok_pat, 0, 4, 2'd2, 0);
        req_click = 1'b1;
        play("ok_click_ign", ok_pat, 4, 18, 2'd2, 1);
        go(0, 1, 0);
        play("ok_b", ok_pat, 0, 4, 2'd2, 0);
        go(0, 0, 1);
        play("ok_preempt_fail", fail_pat, 0, 24, 2'd3, 1);
        go(1, 1, 1);
        play("same_cycle_fail", fail_pat, 0, 24, 2'd3, 1);
        go(0, 1, 0);
        play("ok_retrig_a", ok_pat, 0, 5, 2'd2, 0);
        req_ok = 1'b1;
        play("ok_retrig_b", ok_pat, 5, 6, 2'd2, 0);
        play("ok_retrig_c", ok_pat, 0, 18, 2'd2, 1);
        go(0, 0, 1);
        play("fail_pre_alarm", fail_pat, 0, 10, 2'd3, 0);
        lockout = 1'b1;
        play("fail_gap_lock", fail_pat, 10, 11, 2'd3, 0);
        play("alarm_a", alarm_pat, 0, 5, 2'd3, 0);
        req_fail = 1'b1;
        play("alarm_b", alarm_pat, 5, 23, 2'd3, 0);
        lockout = 1'b0;
        play("alarm_c", alarm_pat, 23, 24, 2'd3, 0);
        chk("alarm_off", 5'b0_0_00_0);
        step();
        chk("alarm_off_nodone", 5'b0_0_00_0);
        go(0, 1, 0);
        play("ok_rst", ok_pat, 0, 3, 2'd2, 0);
        #3 rst = 1'b1;
        #1 chk("async_rst", 5'b0_0_00_0);
        #3 rst = 1'b0;
        step();
        chk("post_rst_a", 5'b0_0_00_0);
        step();
        chk("post_rst_b", 5'b0_0_00_0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
